// File: rtl/vga_frame_reader.sv
// VGA 640x480 timing with 2x upscaled frame-buffer fetch and RGB drive.
// Optional macro VGA_TEST_PATTERN_EN adds the test_pattern colour-bar input.
module vga_frame_reader #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int RD_LATENCY = 1
) (
   input  logic        clk25,
   input  logic        rst,
   output logic [16:0] rd_addr,
   input  logic [11:0] rd_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank_n,
   output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
   ,
   input  logic        test_pattern
`endif
);

   localparam int P       = 2 + RD_LATENCY;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  V_ACT_LL = 10'(V_ACTIVE - 1);
   localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [16:0] STRIDE   = 17'(H_ACTIVE / 2);

   logic [9:0]   r_hcnt;
   logic [9:0]   r_vcnt;
   logic [16:0]  r_line_base;
   logic [16:0]  r_addr;
   logic         w_hwrap;
   logic         w_vwrap;
   logic         w_active;
   logic         w_hs;
   logic         w_vs;
   logic         w_first;

   logic [P-1:0] r_act_d;
   logic [P-1:0] r_hs_d;
   logic [P-1:0] r_vs_d;
   logic [P-1:0] r_fs_d;
   logic [11:0]  r_rgb;
   logic [11:0]  w_rgb;

   assign w_hwrap  = (r_hcnt == H_LAST);
   assign w_vwrap  = (r_vcnt == V_LAST);
   assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
   assign w_hs     = ~((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
   assign w_vs     = ~((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
   assign w_first  = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

   always_ff @(posedge clk25) begin
      if (rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (w_hwrap) begin
         r_hcnt <= '0;
         r_vcnt <= w_vwrap ? 10'd0 : r_vcnt + 10'd1;
      end else begin
         r_hcnt <= r_hcnt + 10'd1;
      end
   end

   // Base advances only after the second copy of each stored line.
   always_ff @(posedge clk25) begin
      if (rst) begin
         r_line_base <= '0;
      end else if (w_hwrap) begin
         if (w_vwrap)
            r_line_base <= '0;
         else if (r_vcnt[0] && (r_vcnt < V_ACT_LL))
            r_line_base <= r_line_base + STRIDE;
      end
   end

   always_ff @(posedge clk25) begin
      if (rst)
         r_addr <= '0;
      else if (w_active)
         r_addr <= r_line_base + 17'(r_hcnt[9:1]);
   end

   assign rd_addr = r_addr;

   always_ff @(posedge clk25) begin
      if (rst) begin
         r_act_d <= '0;
         r_hs_d  <= '1;
         r_vs_d  <= '1;
         r_fs_d  <= '0;
      end else begin
         r_act_d <= {r_act_d[P-2:0], w_active};
         r_hs_d  <= {r_hs_d[P-2:0],  w_hs};
         r_vs_d  <= {r_vs_d[P-2:0],  w_vs};
         r_fs_d  <= {r_fs_d[P-2:0],  w_first};
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0] w_bar;
   logic [2:0] r_bar_d [P];
   logic [P-1:0] r_tp_d;

   always_comb begin
      w_bar = '0;
      for (int k = 1; k < 8; k++)
         if (r_hcnt >= 10'(k * BAR_W))
            w_bar = 3'(k);
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         r_tp_d <= '0;
         for (int i = 0; i < P; i++)
            r_bar_d[i] <= '0;
      end else begin
         r_tp_d     <= {r_tp_d[P-2:0], test_pattern};
         r_bar_d[0] <= w_bar;
         for (int i = 1; i < P; i++)
            r_bar_d[i] <= r_bar_d[i-1];
      end
   end

   // Bar order white..black maps to inverted index bits per channel.
   always_comb begin
      w_rgb = rd_data;
      if (r_tp_d[P-2])
         w_rgb = {{4{~r_bar_d[P-2][1]}},
                  {4{~r_bar_d[P-2][2]}},
                  {4{~r_bar_d[P-2][0]}}};
   end
`else
   always_comb begin
      w_rgb = rd_data;
   end
`endif

   always_ff @(posedge clk25) begin
      if (rst)
         r_rgb <= '0;
      else
         r_rgb <= r_act_d[P-2] ? w_rgb : 12'h000;
   end

   assign vga_r       = r_rgb[11:8];
   assign vga_g       = r_rgb[7:4];
   assign vga_b       = r_rgb[3:0];
   assign vga_hsync   = r_hs_d[P-1];
   assign vga_vsync   = r_vs_d[P-1];
   assign vga_blank_n = r_act_d[P-1];
   assign frame_start = r_fs_d[P-1];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced raster (80x30 total).
// Expected pixels, syncs and addresses come from position arithmetic.
module tb_vga_frame_reader;

   localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 24, VFP = 2, VS = 2, VBP = 2;
   localparam int L  = 2;
   localparam int P  = 2 + L;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FT = HT * VT;
   localparam int STRIDE = HA / 2;
   localparam int NPIX = (VA / 2) * STRIDE;
   localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF,
      12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

   typedef struct packed {
      logic        bn;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [11:0] rgb;
   } exp_t;

   logic        clk25 = 1'b0;
   logic        rst   = 1'b1;
   logic [16:0] rd_addr;
   logic [11:0] rd_data;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hsync, vga_vsync, vga_blank_n, frame_start;
`ifdef VGA_TEST_PATTERN_EN
   logic        test_pattern = 1'b0;
`endif

   always #20 clk25 = ~clk25;

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .RD_LATENCY(L)
   ) dut (
      .clk25       (clk25),
      .rst         (rst),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hsync   (vga_hsync),
      .vga_vsync   (vga_vsync),
      .vga_blank_n (vga_blank_n),
      .frame_start (frame_start)
`ifdef VGA_TEST_PATTERN_EN
      ,
      .test_pattern(test_pattern)
`endif
   );

   // Frame-buffer model: address registered then L clocks to data.
   logic [11:0] mem [NPIX];
   logic [16:0] a_pipe [L];

   initial for (int i = 0; i < L; i++) a_pipe[i] = '0;

   always @(posedge clk25) begin
      a_pipe[0] <= rd_addr;
      for (int i = 1; i < L; i++) a_pipe[i] <= a_pipe[i-1];
   end

   assign rd_data = (int'(a_pipe[L-1]) < NPIX) ? mem[a_pipe[L-1]] : 12'hFFF;

   exp_t        oq [$];
   logic [16:0] aq [$];
   int n_cmp = 0;
   int n_bad = 0;
   int n_msg = 0;

   task automatic report(input string name, input int k,
                         input longint got, input longint want);
      n_bad++;
      if (n_msg < 40) begin
         n_msg++;
         $display("FAIL %s k=%0d got=%h want=%h", name, k, got, want);
      end
   endtask

   // Monitor: k counts clocks since the last reset edge.
   int k = 0;
   int last_fs = -1;
   int cyc = 0;
   bit hs_seen = 0;
   logic hs_prev = 1'b1;

   always @(posedge clk25) begin
      bit r;
      exp_t e, got;
      logic [16:0] ea;
      r = rst;
      #1;
      cyc++;
      if (r) begin
         oq.delete();
         aq.delete();
         k = 0;
         last_fs = -1;
         hs_seen = 0;
      end else begin
         k++;
      end
      got = '{bn: vga_blank_n, hs: vga_hsync, vs: vga_vsync,
              fs: frame_start, rgb: {vga_r, vga_g, vga_b}};
      if (k < P) begin
         e = '{bn: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 12'h000};
      end else if (oq.size() > 0) begin
         e = oq.pop_front();
      end else begin
         e = got;
         report("out_queue_empty", k, 0, 1);
      end
      n_cmp++;
      if (got !== e) report("outputs", k, got, e);

      ea = 17'd0;
      if (k > 0) begin
         if (aq.size() > 0) ea = aq.pop_front();
         else report("addr_queue_empty", k, 0, 1);
      end
      n_cmp++;
      if (rd_addr !== ea) report("rd_addr", k, rd_addr, ea);

      n_cmp++;
      if (int'(rd_addr) >= NPIX) report("addr_bound", k, rd_addr, NPIX - 1);

      if (!r && hs_prev && !vga_hsync && !hs_seen) begin
         hs_seen = 1;
         n_cmp++;
         if (k != HA + HFP + P) report("first_hsync_fall", k, k, HA + HFP + P);
      end
      hs_prev = vga_hsync;

      if (frame_start === 1'b1) begin
         if (last_fs >= 0) begin
            n_cmp++;
            if (cyc - last_fs != FT) report("frame_period", k, cyc - last_fs, FT);
         end
         last_fs = cyc;
      end
   end

   // Driver: one position per clock, expected response queued at issue.
   initial begin
      int pos, last, h, v, rst_at, ncyc, frames;
      bit tp, act;
      exp_t e;
      for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
      pos = 0;
      last = 0;
      tp = 0;
      frames = 0;
      rst_at = 3 + FT + 12 * HT + $urandom_range(0, HT - 1);
      ncyc = rst_at + 2 * FT + 50;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk25);
         if (rst) begin
            pos = 0;
            last = 0;
         end else begin
            pos++;
         end
         h = pos % HT;
         v = (pos / HT) % VT;
         if (h == 0 && v == 0) begin
            tp = (frames == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            frames++;
         end
`ifdef VGA_TEST_PATTERN_EN
         test_pattern = tp;
`else
         tp = 0;
`endif
         act = (h < HA) && (v < VA);
         if (act) last = (v / 2) * STRIDE + h / 2;
         e.bn = act;
         e.hs = !(h >= HA + HFP && h < HA + HFP + HS);
         e.vs = !(v >= VA + VFP && v < VA + VFP + VS);
         e.fs = (h == 0) && (v == 0);
         if (!act)    e.rgb = 12'h000;
         else if (tp) e.rgb = BARS[h / (HA / 8)];
         else         e.rgb = mem[last];
         oq.push_back(e);
         aq.push_back(17'(last));
         rst = (c < 3) || (c == rst_at);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
